// File: rtl/t_counter_bank_pkg.sv
// Shared types for the T flip-flop counter bank: operating modes and mode width.
// Optional feature macro used by the bank: T_COUNTER_SATURATE_EN.
package t_counter_pkg;

    localparam int TC_MODE_W = 2;

    typedef enum logic [TC_MODE_W-1:0] {
        TC_HOLD   = 2'b00,
        TC_UP     = 2'b01,
        TC_DOWN   = 2'b10,
        TC_TOGGLE = 2'b11
    } tc_mode_e;

endpackage

// File: rtl/t_counter_bank_t_ff_cell.sv
// Single-bit T flip-flop with asynchronous reset to a per-cell value and a
// synchronous load that overrides the toggle.
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_counter_bank.sv
// WIDTH-bit counter/toggle register built from t_ff_cell instances.
// Define T_COUNTER_SATURATE_EN to make UP/DOWN saturate instead of wrapping.
module t_counter_bank
    import t_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [TC_MODE_W-1:0] mode,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [WIDTH-1:0]     t_mask,
    output logic [WIDTH-1:0]     q,
    output logic                 tc,
    output logic                 wrap
);

    tc_mode_e         mode_e;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] t_eff;
    logic             wrap_nxt;

    assign mode_e = tc_mode_e'(mode);

    // Prefix AND chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            ones_below[i]  = ones_below[i-1] & q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        t_vec = '0;
        case (mode_e)
            TC_UP:     t_vec = ones_below;
            TC_DOWN:   t_vec = zeros_below;
            TC_TOGGLE: t_vec = t_mask;
            default:   t_vec = '0;
        endcase
    end

    assign tc = ((mode_e == TC_UP) && (q == {WIDTH{1'b1}})) ||
                ((mode_e == TC_DOWN) && (q == {WIDTH{1'b0}}));

`ifdef T_COUNTER_SATURATE_EN
    // At the terminal count all toggles are suppressed so the value sticks.
    assign t_eff = (en && !tc) ? t_vec : '0;
`else
    assign t_eff = en ? t_vec : '0;
`endif

    // Wrap (or saturation hit) is the same event in both builds; load masks it.
    assign wrap_nxt = en & tc & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RST_VAL[i]),
            .ld      (load),
            .d       (load_val[i]),
            .t       (t_eff[i]),
            .q       (q[i])
        );
    end

endmodule

// File: tb/tb_t_counter_bank.sv
// Bench for t_counter_bank: directed table, reset sequence, randomized run vs model.
// Honors T_COUNTER_SATURATE_EN when the build defines it.
module tb_t_counter_bank;

    localparam int           W   = 8;
    localparam logic [W-1:0] RV  = 8'h5A;
    localparam logic [W-1:0] MAX = 8'hFF;
    localparam logic [1:0]   M_HOLD = 2'b00;
    localparam logic [1:0]   M_UP   = 2'b01;
    localparam logic [1:0]   M_DOWN = 2'b10;
    localparam logic [1:0]   M_TOG  = 2'b11;
`ifdef T_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         load;
    logic [1:0]   mode;
    logic [W-1:0] load_val;
    logic [W-1:0] t_mask;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    t_counter_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .t_mask   (t_mask),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         ld;
        logic [W-1:0] lv;
        logic         e;
        logic [1:0]   m;
        logic [W-1:0] msk;
        logic [W-1:0] exp_qv;
        logic         exp_tc;
        logic         exp_wrap;
    } vec_t;

    vec_t         vecs[$];
    logic [W+1:0] exp_q[$];
    logic [W-1:0] m_q;
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic vec_t mk(string nm, logic ld, logic [W-1:0] lv, logic e,
                                logic [1:0] m, logic [W-1:0] msk,
                                logic [W-1:0] xq, logic xtc, logic xw);
        vec_t v;
        v.name = nm; v.ld = ld; v.lv = lv; v.e = e; v.m = m; v.msk = msk;
        v.exp_qv = xq; v.exp_tc = xtc; v.exp_wrap = xw;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e,
                         input logic [1:0] m, input logic [W-1:0] msk);
        @(negedge clk);
        load = ld; load_val = lv; en = e; mode = m; t_mask = msk;
    endtask

    // Reference: the counter as an integer that moves by +1, -1 or xor mask.
    function automatic logic [W+1:0] model_step(logic ld, logic [W-1:0] lv, logic e,
                                                logic [1:0] m, logic [W-1:0] msk);
        logic [W-1:0] nq;
        logic         w;
        logic         t;
        nq = m_q;
        w  = 1'b0;
        if (ld) begin
            nq = lv;
        end else if (e) begin
            if (m == M_UP) begin
                if (m_q == MAX) begin
                    w  = 1'b1;
                    nq = SAT ? MAX : '0;
                end else nq = m_q + 8'd1;
            end else if (m == M_DOWN) begin
                if (m_q == 0) begin
                    w  = 1'b1;
                    nq = SAT ? '0 : MAX;
                end else nq = m_q - 8'd1;
            end else if (m == M_TOG) begin
                nq = m_q ^ msk;
            end
        end
        t = ((m == M_UP) && (nq == MAX)) || ((m == M_DOWN) && (nq == 0));
        m_q = nq;
        return {nq, t, w};
    endfunction

    task automatic compare_scoreboard(input int idx);
        logic [W+1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check($sformatf("rnd%0d_queue_empty", idx), 1, 0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_q", idx), 32'(q), 32'(e[W+1:2]));
            check($sformatf("rnd%0d_tc", idx), 32'(tc), 32'(e[1]));
            check($sformatf("rnd%0d_wrap", idx), 32'(wrap), 32'(e[0]));
        end
    endtask

    initial begin
        logic         r_ld;
        logic         r_e;
        logic [1:0]   r_m;
        logic [W-1:0] r_lv;
        logic [W-1:0] r_msk;

        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = M_HOLD;
        load_val = '0; t_mask = '0;
        #12;
        check("reset_q", 32'(q), 32'(RV));
        check("reset_wrap", 32'(wrap), 0);
        check("reset_tc", 32'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // up wrap
        vecs.push_back(mk("up_load_fe", 1, 8'hFE, 0, M_UP, 0, 8'hFE, 0, 0));
        vecs.push_back(mk("up_to_ff",   0, 0, 1, M_UP, 0, 8'hFF, 1, 0));
        vecs.push_back(mk("up_wrap",    0, 0, 1, M_UP, 0, SAT ? 8'hFF : 8'h00, SAT, 1));
        vecs.push_back(mk("up_after",   0, 0, 1, M_UP, 0, SAT ? 8'hFF : 8'h01, SAT, SAT));
        // down wrap
        vecs.push_back(mk("dn_load_01", 1, 8'h01, 0, M_DOWN, 0, 8'h01, 0, 0));
        vecs.push_back(mk("dn_to_00",   0, 0, 1, M_DOWN, 0, 8'h00, 1, 0));
        vecs.push_back(mk("dn_wrap",    0, 0, 1, M_DOWN, 0, SAT ? 8'h00 : 8'hFF, SAT, 1));
        vecs.push_back(mk("dn_after",   0, 0, 1, M_DOWN, 0, SAT ? 8'h00 : 8'hFE, SAT, SAT));
        // toggle
        vecs.push_back(mk("tog_load",   1, 8'h0F, 0, M_TOG, 0, 8'h0F, 0, 0));
        vecs.push_back(mk("tog_1",      0, 0, 1, M_TOG, 8'hA5, 8'hAA, 0, 0));
        vecs.push_back(mk("tog_2",      0, 0, 1, M_TOG, 8'hA5, 8'h0F, 0, 0));
        // load beats en at terminal count; tc ignores en
        vecs.push_back(mk("pri_load_ff", 1, 8'hFF, 0, M_UP, 0, 8'hFF, 1, 0));
        vecs.push_back(mk("pri_ld_en",   1, 8'h33, 1, M_UP, 0, 8'h33, 0, 0));
        vecs.push_back(mk("pri_hold1",   0, 0, 0, M_UP, 0, 8'h33, 0, 0));
        vecs.push_back(mk("pri_hold2",   0, 0, 0, M_UP, 0, 8'h33, 0, 0));
        vecs.push_back(mk("hold_mode",   0, 0, 1, M_HOLD, 8'hFF, 8'h33, 0, 0));
        // saturation / wrap boundary, plus a same-cycle mode change
        vecs.push_back(mk("sat_load_ff", 1, 8'hFF, 0, M_UP, 0, 8'hFF, 1, 0));
        vecs.push_back(mk("sat_1",       0, 0, 1, M_UP, 0, SAT ? 8'hFF : 8'h00, SAT, 1));
        vecs.push_back(mk("sat_2",       0, 0, 1, M_UP, 0, SAT ? 8'hFF : 8'h01, SAT, SAT));
        vecs.push_back(mk("mode_sw_ld",  1, 8'h01, 0, M_UP, 0, 8'h01, 0, 0));
        vecs.push_back(mk("mode_sw_dn",  0, 0, 1, M_DOWN, 0, 8'h00, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].m, vecs[i].msk);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_qv));
            check({vecs[i].name, "_tc"}, 32'(tc), 32'(vecs[i].exp_tc));
            check({vecs[i].name, "_wrap"}, 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // reset mid-cycle while wrap is high, then resume counting
        drive(1, 8'hFF, 0, M_UP, 0);
        drive(0, 0, 1, M_UP, 0);
        @(posedge clk);
        #1;
        check("pre_rst_wrap", 32'(wrap), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(q), 32'(RV));
        check("mid_rst_wrap", 32'(wrap), 0);
        check("mid_rst_tc", 32'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("resume_q", 32'(q), 32'(RV + 8'd1));
        check("resume_wrap", 32'(wrap), 0);

        // randomized run against the arithmetic model
        m_q = q;
        for (int i = 0; i < 300; i++) begin
            r_ld  = (i == 0) || ($urandom_range(0, 7) == 0);
            r_e   = ($urandom_range(0, 3) != 0);
            r_m   = 2'($urandom_range(0, 3));
            r_msk = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       r_lv = 8'hFF;
                1:       r_lv = 8'h00;
                2:       r_lv = 8'hFE;
                3:       r_lv = 8'h01;
                default: r_lv = 8'($urandom);
            endcase
            drive(r_ld, r_lv, r_e, r_m, r_msk);
            exp_q.push_back(model_step(r_ld, r_lv, r_e, r_m, r_msk));
            compare_scoreboard(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
